// File: rtl/game_pkg.sv
// Shared encodings for the player controllers and the match round controller.
// Player state bus values, game phases, round winner codes and spawn points.
package game_pkg;

    localparam int PLAYER_WIDTH = 10;
    localparam logic [PLAYER_WIDTH-1:0] P1_SPAWN_X = 10'd100;
    localparam logic [PLAYER_WIDTH-1:0] P2_SPAWN_X = 10'd500;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WALK_FWD  = 4'd1;
    localparam logic [3:0] S_WALK_BACK = 4'd2;
    localparam logic [3:0] S_CROUCH    = 4'd3;
    localparam logic [3:0] S_JUMP      = 4'd4;
    localparam logic [3:0] S_PUNCH     = 4'd5;
    localparam logic [3:0] S_KICK      = 4'd6;
    localparam logic [3:0] S_SPECIAL   = 4'd7;
    localparam logic [3:0] S_BLOCK     = 4'd8;
    localparam logic [3:0] S_HITSTUN   = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN = 4'd10;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_COUNTDOWN = 3'd1,
        PH_FIGHT     = 3'd2,
        PH_ROUND_END = 3'd3,
        PH_MATCH_END = 3'd4
    } phase_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/frame_second_timer.sv
// Frame-driven seconds down-counter with a sub-second frame counter.
// load_i reloads seconds and clears the frame count; wrap_o pulses on each second.
module frame_second_timer #(
    parameter int FRAMES = 60,
    parameter int SEC_W = 7,
    parameter logic [SEC_W-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [SEC_W-1:0] load_val_i,
    output logic [SEC_W-1:0] seconds_o,
    output logic             wrap_o
);

    localparam int SUB_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [SEC_W-1:0] sec_q, sec_d;

    assign wrap_o = enable_i && (sub_q == SUB_W'(FRAMES - 1));
    assign seconds_o = sec_q;

    always_comb begin
        sub_d = sub_q;
        sec_d = sec_q;
        if (load_i) begin
            sub_d = '0;
            sec_d = load_val_i;
        end else if (enable_i) begin
            if (wrap_o) begin
                sub_d = '0;
                // Saturate so an expired timer stays at zero.
                sec_d = (sec_q == '0) ? '0 : sec_q - 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sub_q <= '0;
            sec_q <= RESET_VAL;
        end else begin
            sub_q <= sub_d;
            sec_q <= sec_d;
        end
    end

endmodule

// File: rtl/match_round_controller.sv
// Two-player match sequencer: title, countdown, fight, round end, match end.
// Build option: define CHIP_DAMAGE_EN to let early-round block-stun cost health.
module match_round_controller
    import game_pkg::*;
#(
    parameter int MAX_HEALTH       = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int FRAMES_PER_SEC   = 60,
    parameter int ROUND_TIME_S     = 60,
    parameter int COUNTDOWN_S      = 3,
    parameter int ROUND_END_FRAMES = 120
) (
    input  logic       clk_60Hz,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    output logic       player_reset,
    output logic       play_enable,
    output logic [2:0] game_phase,
    output logic [1:0] countdown_value,
    output logic [6:0] round_timer,
    output logic [3:0] p1_health,
    output logic [3:0] p2_health,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] round_winner
);

    localparam int HW  = 4;
    localparam int RW  = 2;
    localparam int TW  = 7;
    localparam int CW  = 2;
    localparam int REW = (ROUND_END_FRAMES > 1) ? $clog2(ROUND_END_FRAMES) : 1;

    phase_e         phase_q, phase_d;
    logic [3:0]     prev1_q, prev2_q;
    logic [HW-1:0]  h1_q, h1_d, h2_q, h2_d;
    logic [RW-1:0]  r1_q, r1_d, r2_q, r2_d;
    logic [1:0]     win_q, win_d;
    logic [REW-1:0] re_cnt_q, re_cnt_d;

    logic          cd_load, cd_en, cd_wrap;
    logic          rt_load, rt_en, rt_wrap_unused;
    logic [CW-1:0] cd_sec;
    logic [TW-1:0] rt_sec;
    logic          enter_cd;
    logic          dmg1, dmg2;

    frame_second_timer #(
        .FRAMES    (FRAMES_PER_SEC),
        .SEC_W     (CW),
        .RESET_VAL ('0)
    ) u_countdown (
        .clk_i      (clk_60Hz),
        .reset_i    (reset),
        .load_i     (cd_load),
        .enable_i   (cd_en),
        .load_val_i (CW'(COUNTDOWN_S)),
        .seconds_o  (cd_sec),
        .wrap_o     (cd_wrap)
    );

    frame_second_timer #(
        .FRAMES    (FRAMES_PER_SEC),
        .SEC_W     (TW),
        .RESET_VAL (TW'(ROUND_TIME_S))
    ) u_round_timer (
        .clk_i      (clk_60Hz),
        .reset_i    (reset),
        .load_i     (rt_load),
        .enable_i   (rt_en),
        .load_val_i (TW'(ROUND_TIME_S)),
        .seconds_o  (rt_sec),
        .wrap_o     (rt_wrap_unused)
    );

`ifdef CHIP_DAMAGE_EN
    logic early_half;
    assign early_half = rt_sec > TW'(ROUND_TIME_S / 2);
    assign dmg1 = ((p1_state == S_HITSTUN) && (prev1_q != S_HITSTUN))
               || (early_half && (p1_state == S_BLOCKSTUN)
                   && (prev1_q != S_BLOCKSTUN));
    assign dmg2 = ((p2_state == S_HITSTUN) && (prev2_q != S_HITSTUN))
               || (early_half && (p2_state == S_BLOCKSTUN)
                   && (prev2_q != S_BLOCKSTUN));
`else
    assign dmg1 = (p1_state == S_HITSTUN) && (prev1_q != S_HITSTUN);
    assign dmg2 = (p2_state == S_HITSTUN) && (prev2_q != S_HITSTUN);
`endif

    always_comb begin
        phase_d  = phase_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        win_d    = win_q;
        re_cnt_d = re_cnt_q;
        cd_load  = 1'b0;
        cd_en    = 1'b0;
        rt_load  = 1'b0;
        rt_en    = 1'b0;
        enter_cd = 1'b0;
        unique case (phase_q)
            PH_IDLE: begin
                if (start) enter_cd = 1'b1;
            end
            PH_COUNTDOWN: begin
                cd_en = 1'b1;
                if (cd_wrap && (cd_sec == CW'(1))) phase_d = PH_FIGHT;
            end
            PH_FIGHT: begin
                rt_en = 1'b1;
                if (dmg1 && (h1_q != '0)) h1_d = h1_q - 1'b1;
                if (dmg2 && (h2_q != '0)) h2_d = h2_q - 1'b1;
                // Decision uses registered health/timer; KO outranks timeout.
                if ((h1_q == '0) || (h2_q == '0) || (rt_sec == '0)) begin
                    phase_d  = PH_ROUND_END;
                    re_cnt_d = '0;
                    if ((h1_q == '0) && (h2_q == '0)) win_d = WIN_NONE;
                    else if (h1_q == '0)             win_d = WIN_P2;
                    else if (h2_q == '0)             win_d = WIN_P1;
                    else if (h1_q > h2_q)            win_d = WIN_P1;
                    else if (h2_q > h1_q)            win_d = WIN_P2;
                    else                             win_d = WIN_NONE;
                    if (win_d == WIN_P1) r1_d = r1_q + 1'b1;
                    if (win_d == WIN_P2) r2_d = r2_q + 1'b1;
                end
            end
            PH_ROUND_END: begin
                if (re_cnt_q == REW'(ROUND_END_FRAMES - 1)) begin
                    if ((r1_q == RW'(ROUNDS_TO_WIN))
                        || (r2_q == RW'(ROUNDS_TO_WIN)))
                        phase_d = PH_MATCH_END;
                    else
                        enter_cd = 1'b1;
                end else begin
                    re_cnt_d = re_cnt_q + 1'b1;
                end
            end
            PH_MATCH_END: begin
                if (start) begin
                    enter_cd = 1'b1;
                    r1_d     = '0;
                    r2_d     = '0;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
        if (enter_cd) begin
            phase_d = PH_COUNTDOWN;
            h1_d    = HW'(MAX_HEALTH);
            h2_d    = HW'(MAX_HEALTH);
            win_d   = WIN_NONE;
            cd_load = 1'b1;
            rt_load = 1'b1;
        end
    end

    always_ff @(posedge clk_60Hz) begin
        if (reset) begin
            phase_q  <= PH_IDLE;
            prev1_q  <= '0;
            prev2_q  <= '0;
            h1_q     <= HW'(MAX_HEALTH);
            h2_q     <= HW'(MAX_HEALTH);
            r1_q     <= '0;
            r2_q     <= '0;
            win_q    <= WIN_NONE;
            re_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            prev1_q  <= p1_state;
            prev2_q  <= p2_state;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            win_q    <= win_d;
            re_cnt_q <= re_cnt_d;
        end
    end

    assign player_reset    = (phase_q != PH_FIGHT);
    assign play_enable     = (phase_q == PH_FIGHT);
    assign game_phase      = phase_q;
    assign countdown_value = cd_sec;
    assign round_timer     = rt_sec;
    assign p1_health       = h1_q;
    assign p2_health       = h2_q;
    assign p1_rounds       = r1_q;
    assign p2_rounds       = r2_q;
    assign round_winner    = win_q;

endmodule

// File: tb/tb_match_round_controller.sv
// Directed bench for match_round_controller: countdown, hits, KO, draw,
// timeout decisions, match end, restart and mid-fight reset.
module tb_match_round_controller;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] p1_state, p2_state;
    logic       player_reset, play_enable;
    logic [2:0] game_phase;
    logic [1:0] countdown_value;
    logic [6:0] round_timer;
    logic [3:0] p1_health, p2_health;
    logic [1:0] p1_rounds, p2_rounds, round_winner;

    int errors = 0;
    int checks = 0;

    match_round_controller dut (
        .clk_60Hz        (clk),
        .reset           (reset),
        .start           (start),
        .p1_state        (p1_state),
        .p2_state        (p2_state),
        .player_reset    (player_reset),
        .play_enable     (play_enable),
        .game_phase      (game_phase),
        .countdown_value (countdown_value),
        .round_timer     (round_timer),
        .p1_health       (p1_health),
        .p2_health       (p2_health),
        .p1_rounds       (p1_rounds),
        .p2_rounds       (p2_rounds),
        .round_winner    (round_winner)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_phase"}, 32'(game_phase), 0);
        chk({tag, "_preset"}, 32'(player_reset), 1);
        chk({tag, "_pen"}, 32'(play_enable), 0);
        chk({tag, "_h1"}, 32'(p1_health), 3);
        chk({tag, "_h2"}, 32'(p2_health), 3);
        chk({tag, "_r1"}, 32'(p1_rounds), 0);
        chk({tag, "_r2"}, 32'(p2_rounds), 0);
        chk({tag, "_timer"}, 32'(round_timer), 60);
        chk({tag, "_cd"}, 32'(countdown_value), 0);
        chk({tag, "_win"}, 32'(round_winner), 0);
    endtask

    task automatic hit(input logic a, input logic b);
        if (a) p1_state = 4'd9;
        if (b) p2_state = 4'd9;
        step(1);
        p1_state = 4'd0;
        p2_state = 4'd0;
        step(1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        p1_state = 4'd0;
        p2_state = 4'd0;
        step(2);
        chk_reset_state("rst");
        reset = 1'b0;
        step(3);
        chk("idle_hold", 32'(game_phase), 0);

        // Round 1: countdown 3,2,1 then fight at frame 180
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("cd_enter", 32'(game_phase), 1);
        chk("cd_3", 32'(countdown_value), 3);
        step(59);
        chk("cd_3_end", 32'(countdown_value), 3);
        step(1);
        chk("cd_2", 32'(countdown_value), 2);
        step(60);
        chk("cd_1", 32'(countdown_value), 1);
        step(59);
        chk("cd_last", 32'(game_phase), 1);
        step(1);
        chk("fight_phase", 32'(game_phase), 2);
        chk("fight_cd0", 32'(countdown_value), 0);
        chk("fight_pen", 32'(play_enable), 1);
        chk("fight_preset", 32'(player_reset), 0);

        // Held HITSTUN costs exactly one point
        p2_state = 4'd9;
        step(1);
        chk("hit_once", 32'(p2_health), 2);
        step(19);
        chk("hit_held", 32'(p2_health), 2);
        chk("hit_p1_clean", 32'(p1_health), 3);
        p2_state = 4'd0;
        step(1);
        hit(1'b0, 1'b1);
        chk("p2_h1", 32'(p2_health), 1);
        p2_state = 4'd9;
        step(1);
        chk("p2_ko_h", 32'(p2_health), 0);
        chk("p2_ko_still", 32'(game_phase), 2);
        p2_state = 4'd0;
        step(1);
        chk("ko_re", 32'(game_phase), 3);
        chk("ko_win", 32'(round_winner), 1);
        chk("ko_r1", 32'(p1_rounds), 1);
        chk("ko_preset", 32'(player_reset), 1);
        step(119);
        chk("re_hold", 32'(game_phase), 3);
        step(1);
        chk("re_to_cd", 32'(game_phase), 1);
        chk("re_reload_h2", 32'(p2_health), 3);
        chk("re_reload_cd", 32'(countdown_value), 3);

        // Round 2: simultaneous KO is a draw
        step(180);
        chk("r2_fight", 32'(game_phase), 2);
        hit(1'b1, 1'b1);
        hit(1'b1, 1'b1);
        chk("dbl_h1", 32'(p1_health), 1);
        chk("dbl_h2", 32'(p2_health), 1);
        p1_state = 4'd9;
        p2_state = 4'd9;
        step(1);
        chk("dbl_ko_h1", 32'(p1_health), 0);
        chk("dbl_ko_h2", 32'(p2_health), 0);
        p1_state = 4'd0;
        p2_state = 4'd0;
        step(1);
        chk("dbl_re", 32'(game_phase), 3);
        chk("dbl_win", 32'(round_winner), 0);
        chk("dbl_r1", 32'(p1_rounds), 1);
        chk("dbl_r2", 32'(p2_rounds), 0);
        step(120);
        chk("dbl_to_cd", 32'(game_phase), 1);

        // Round 3: equal-health timeout is a draw
        step(180);
        chk("r3_fight", 32'(game_phase), 2);
        chk("r3_timer", 32'(round_timer), 60);
        step(60);
        chk("r3_timer59", 32'(round_timer), 59);
        step(3540);
        chk("r3_timer0", 32'(round_timer), 0);
        chk("r3_still", 32'(game_phase), 2);
        step(1);
        chk("to_re", 32'(game_phase), 3);
        chk("to_draw", 32'(round_winner), 0);
        chk("to_r1", 32'(p1_rounds), 1);
        step(120);

        // Round 4: timeout with P1 at 2, P2 at 3 -> P2 wins
        step(180);
        chk("r4_fight", 32'(game_phase), 2);
        hit(1'b1, 1'b0);
        chk("r4_h1", 32'(p1_health), 2);
        step(3598);
        chk("r4_timer0", 32'(round_timer), 0);
        step(1);
        chk("r4_re", 32'(game_phase), 3);
        chk("r4_win", 32'(round_winner), 2);
        chk("r4_r2", 32'(p2_rounds), 1);
        step(120);

        // Round 5: HITSTUN during countdown is ignored, then P1 takes match
        p1_state = 4'd9;
        step(10);
        p1_state = 4'd0;
        chk("cd_no_dmg", 32'(p1_health), 3);
        step(170);
        chk("r5_fight", 32'(game_phase), 2);
        chk("r5_h1", 32'(p1_health), 3);
        hit(1'b0, 1'b1);
        hit(1'b0, 1'b1);
        hit(1'b0, 1'b1);
        chk("r5_re", 32'(game_phase), 3);
        chk("r5_r1", 32'(p1_rounds), 2);
        step(120);
        chk("me_phase", 32'(game_phase), 4);
        chk("me_win", 32'(round_winner), 1);
        step(10);
        chk("me_hold", 32'(game_phase), 4);
        chk("me_preset", 32'(player_reset), 1);

        // Restart clears rounds, then reset mid-fight
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("rs_phase", 32'(game_phase), 1);
        chk("rs_r1", 32'(p1_rounds), 0);
        chk("rs_r2", 32'(p2_rounds), 0);
        step(180);
        chk("rs_fight", 32'(game_phase), 2);
        hit(1'b1, 1'b0);
        step(70);
        reset = 1'b1;
        step(1);
        chk_reset_state("midrst");
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
